// File: rtl/video_ts_render.sv
`default_nettype none
// ============================================================================
// Module      : video_ts_render
// Description : Tile/sprite line renderer. It takes one render task per
//               tsr_go and fetches the 4bpp graphics words from DRAM. A small
//               FIFO buffers the words, and each word is expanded into four
//               pixel slots. Opaque, on-screen pixels are written into the
//               line buffer, tagged with the task palette.
// Revision    : 1.0 - initial release
// ============================================================================
module video_ts_render #(
    parameter int VIS_W  = 360,
    parameter int FIFO_D = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tsr_go,
    input  logic [5:0]  tsr_addr,
    input  logic [8:0]  tsr_line,
    input  logic [7:0]  tsr_page,
    input  logic [8:0]  tsr_x,
    input  logic [2:0]  tsr_xs,
    input  logic        tsr_xf,
    input  logic [3:0]  tsr_pal,
    output logic        tsr_rdy,
    output logic [20:0] dram_addr,
    output logic        dram_req,
    input  logic        dram_next,
    input  logic [15:0] dram_rdata,
    output logic        lb_we,
    output logic [8:0]  lb_waddr,
    output logic [7:0]  lb_wdata
);

    localparam int              c_pw       = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int              c_cw       = $clog2(FIFO_D + 1);
    localparam logic [c_cw-1:0] c_full     = c_cw'(FIFO_D);
    localparam logic [c_cw-1:0] c_one      = c_cw'(1);
    localparam logic [c_pw-1:0] c_last_ptr = c_pw'(FIFO_D - 1);
    localparam logic [9:0]      c_vis_w    = 10'(VIS_W);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    // Task fields captured on acceptance
    logic [5:0]      r_addr;
    logic [8:0]      r_line;
    logic [7:0]      r_page;
    logic [8:0]      r_x;
    logic [2:0]      r_xs;
    logic            r_xf;
    logic [3:0]      r_pal;

    // Fetch side: next word index and words still to request
    logic [4:0]      r_k;
    logic [4:0]      r_words_left;
    // Serializer side: word index and slot within the word at the FIFO head
    logic [3:0]      r_pk;
    logic [1:0]      r_j;

    logic [15:0]     r_fifo [FIFO_D];
    logic [c_pw-1:0] r_wp;
    logic [c_pw-1:0] r_rp;
    logic [c_cw-1:0] r_cnt;

    logic            w_accept;
    logic            w_req;
    logic            w_push;
    logic            w_slot;
    logic            w_pop;
    logic [c_pw-1:0] w_wp_nxt;
    logic [c_pw-1:0] w_rp_nxt;
    logic [15:0]     w_head;
    logic [3:0]      w_pix;
    logic [5:0]      w_p;
    logic [5:0]      w_off;
    logic [8:0]      w_x;
    logic [6:0]      w_wi;
    logic [7:0]      w_bank;

    assign w_accept = (r_state == c_st_idle) && tsr_go && !start;
    assign w_req    = (r_state == c_st_fetch) && (r_words_left != 5'd0) && (r_cnt != c_full);
    assign w_push   = w_req && dram_next;
    // The head of the FIFO is the word being serialized. It leaves the FIFO after its fourth slot.
    assign w_slot   = (r_cnt != '0);
    assign w_pop    = w_slot && (r_j == 2'd3);
    assign w_wp_nxt = (r_wp == c_last_ptr) ? '0 : r_wp + c_pw'(1);
    assign w_rp_nxt = (r_rp == c_last_ptr) ? '0 : r_rp + c_pw'(1);
    assign w_head   = r_fifo[r_rp];

    // Graphics address: the bank is the page plus the line's upper bits, and the low 7 bits are the wrapped word index
    assign w_wi      = {r_addr, 1'b0} + {2'b00, r_k};
    assign w_bank    = r_page + {5'b00000, r_line[8:6]};
    assign dram_addr = {w_bank, r_line[5:0], w_wi};
    assign dram_req  = w_req;
    assign tsr_rdy   = (r_state == c_st_idle);

    // Pixel position in the slice. W-1 is {xs,3'b111}, so the flipped offset never goes negative.
    assign w_p   = {r_pk, r_j};
    assign w_off = r_xf ? ({r_xs, 3'b111} - w_p) : w_p;
    assign w_x   = r_x + {3'b000, w_off};

    // Select the current nibble, leftmost pixel first
    always_comb begin
        w_pix = 4'd0;
        case (r_j)
            2'd0:    w_pix = w_head[15:12];
            2'd1:    w_pix = w_head[11:8];
            2'd2:    w_pix = w_head[7:4];
            default: w_pix = w_head[3:0];
        endcase
    end

    assign lb_we    = w_slot && (w_pix != 4'd0) && ({1'b0, w_x} < c_vis_w);
    assign lb_waddr = w_slot ? w_x : 9'd0;
    assign lb_wdata = w_slot ? {r_pal, w_pix} : 8'd0;

    // State register; start acts as a soft reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. The task ends after the last slot of the last word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) w_state_nxt = c_st_fetch;
            end
            c_st_fetch: begin
                if (w_push && (r_words_left == 5'd1)) w_state_nxt = c_st_drain;
            end
            c_st_drain: begin
                if (w_pop && (r_cnt == c_one) && (r_words_left == 5'd0)) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
        if (start) w_state_nxt = c_st_idle;
    end

    // Capture the task descriptor when a task is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= 6'd0;
            r_line <= 9'd0;
            r_page <= 8'd0;
            r_x    <= 9'd0;
            r_xs   <= 3'd0;
            r_xf   <= 1'b0;
            r_pal  <= 4'd0;
        end else if (w_accept) begin
            r_addr <= tsr_addr;
            r_line <= tsr_line;
            r_page <= tsr_page;
            r_x    <= tsr_x;
            r_xs   <= tsr_xs;
            r_xf   <= tsr_xf;
            r_pal  <= tsr_pal;
        end
    end

    // FIFO storage. Only the count and pointers matter after a reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wp] <= dram_rdata;
        end
    end

    // Fetch/serializer counters and FIFO bookkeeping; start drops any work in flight
    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_k          <= 5'd0;
            r_words_left <= 5'd0;
            r_pk         <= 4'd0;
            r_j          <= 2'd0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
        end else begin
            if (w_accept) begin
                r_k          <= 5'd0;
                r_words_left <= {1'b0, tsr_xs, 1'b0} + 5'd2;
                r_pk         <= 4'd0;
                r_j          <= 2'd0;
            end
            if (w_push) begin
                r_wp         <= w_wp_nxt;
                r_k          <= r_k + 5'd1;
                r_words_left <= r_words_left - 5'd1;
            end
            if (w_slot) begin
                r_j <= r_j + 2'd1;
                if (w_pop) begin
                    r_rp <= w_rp_nxt;
                    r_pk <= r_pk + 4'd1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_one;
                2'b01:   r_cnt <= r_cnt - c_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_ts_render.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_ts_render
// Description : Bench for video_ts_render. A reference model computes the
//               expected fetch addresses and line-buffer writes directly
//               from each task descriptor and its graphics words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_ts_render;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        tsr_go;
    logic [5:0]  tsr_addr;
    logic [8:0]  tsr_line;
    logic [7:0]  tsr_page;
    logic [8:0]  tsr_x;
    logic [2:0]  tsr_xs;
    logic        tsr_xf;
    logic [3:0]  tsr_pal;
    logic        tsr_rdy;
    logic [20:0] dram_addr;
    logic        dram_req;
    logic        dram_next;
    logic [15:0] dram_rdata;
    logic        lb_we;
    logic [8:0]  lb_waddr;
    logic [7:0]  lb_wdata;

    always #5 clk = ~clk;

    video_ts_render #(.VIS_W(360), .FIFO_D(2)) dut (
        .clk(clk), .rst(rst), .start(start), .tsr_go(tsr_go),
        .tsr_addr(tsr_addr), .tsr_line(tsr_line), .tsr_page(tsr_page),
        .tsr_x(tsr_x), .tsr_xs(tsr_xs), .tsr_xf(tsr_xf), .tsr_pal(tsr_pal),
        .tsr_rdy(tsr_rdy), .dram_addr(dram_addr), .dram_req(dram_req),
        .dram_next(dram_next), .dram_rdata(dram_rdata),
        .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] data [16];
    logic [16:0] exp_wr [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_fields();
        tsr_addr = 6'($urandom);
        tsr_line = 9'($urandom);
        tsr_page = 8'($urandom);
        tsr_x    = 9'($urandom);
        tsr_xs   = 3'($urandom);
        tsr_xf   = 1'($urandom);
        tsr_pal  = 4'($urandom);
    endtask

    task automatic random_data();
        logic [15:0] w;
        for (int k = 0; k < 16; k++) begin
            w = 16'd0;
            for (int j = 0; j < 4; j++) begin
                w = {w[11:0], ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15))};
            end
            data[k] = w;
        end
    endtask

    // Runs one task to completion against the model of fetches and writes
    task automatic run_task(input logic [5:0] a, input logic [8:0] ln, input logic [7:0] pg,
                            input logic [8:0] tx, input logic [2:0] xs, input logic xf,
                            input logic [3:0] pal, input int stall_at, input bit busy_go,
                            input bit rate_full, input string name);
        int nw, w, kf, stall_left, pix, p, off, xx, wi;
        int exp_a [16];
        bit done, stall_done, saw_gap;
        logic [16:0] e;
        nw = 2 * (int'(xs) + 1);
        w  = 8 * (int'(xs) + 1);
        exp_wr.delete();
        for (int k = 0; k < nw; k++) begin
            wi = (2 * int'(a) + k) % 128;
            exp_a[k] = ((int'(pg) + int'(ln) / 64) % 256) * 8192 + (int'(ln) % 64) * 128 + wi;
            for (int j = 0; j < 4; j++) begin
                pix = (int'(data[k]) >> (12 - 4 * j)) & 15;
                p   = 4 * k + j;
                off = xf ? (w - 1 - p) : p;
                xx  = (int'(tx) + off) % 512;
                if (pix != 0 && xx < 360) exp_wr.push_back({9'(xx), pal, 4'(pix)});
            end
        end

        total++;
        if (tsr_rdy !== 1'b1) begin
            bad++;
            $display("FAIL %s rdy_before_go: got %b want 1", name, tsr_rdy);
        end
        tsr_addr = a; tsr_line = ln; tsr_page = pg; tsr_x = tx;
        tsr_xs = xs; tsr_xf = xf; tsr_pal = pal; tsr_go = 1'b1;
        tick();
        tsr_go = 1'b0;
        scramble_fields();
        total++;
        if (tsr_rdy !== 1'b0) begin
            bad++;
            $display("FAIL %s rdy_busy: got %b want 0", name, tsr_rdy);
        end

        kf = 0; stall_left = 0; stall_done = 0; saw_gap = 0; done = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (tsr_rdy === 1'b1) begin
                done = 1;
                break;
            end
            if (lb_we === 1'b1) begin
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_write: got x=%0d d=%h want no write", name, lb_waddr, lb_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    if ({lb_waddr, lb_wdata} !== e) begin
                        bad++;
                        $display("FAIL %s write: got x=%0d d=%h want x=%0d d=%h",
                                 name, lb_waddr, lb_wdata, e[16:8], e[7:0]);
                    end
                end
            end
            if (dram_req !== 1'b1 && kf < nw) saw_gap = 1;
            if (stall_at >= 0 && !stall_done && kf == stall_at) begin
                stall_left = 10;
                stall_done = 1;
            end
            if (stall_left > 0) begin
                dram_next = 1'b0;
                if (stall_left == 1) begin
                    total++;
                    if (lb_we !== 1'b0 || tsr_rdy !== 1'b0 || dram_req !== 1'b1) begin
                        bad++;
                        $display("FAIL %s stall_state: got we=%b rdy=%b req=%b want 0 0 1",
                                 name, lb_we, tsr_rdy, dram_req);
                    end
                end
                stall_left--;
            end else if (rate_full) begin
                dram_next = 1'b1;
            end else begin
                dram_next = ($urandom_range(0, 3) != 0);
            end
            if (dram_req === 1'b1 && dram_next === 1'b1) begin
                total++;
                if (kf >= nw) begin
                    bad++;
                    $display("FAIL %s extra_fetch: got addr=%h want no fetch", name, dram_addr);
                    dram_rdata = 16'($urandom);
                end else begin
                    if (dram_addr !== 21'(exp_a[kf])) begin
                        bad++;
                        $display("FAIL %s fetch_addr[%0d]: got %h want %h", name, kf, dram_addr, 21'(exp_a[kf]));
                    end
                    dram_rdata = data[kf];
                end
                kf++;
            end else begin
                dram_rdata = 16'($urandom);
            end
            tsr_go = busy_go && (cyc == 3);
            tick();
        end
        dram_next = 1'b0;
        tsr_go    = 1'b0;

        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: got rdy=%b want 1 within budget", name, tsr_rdy);
        end
        total++;
        if (kf != nw) begin
            bad++;
            $display("FAIL %s fetch_count: got %0d want %0d", name, kf, nw);
        end
        total++;
        if (exp_wr.size() != 0) begin
            bad++;
            $display("FAIL %s missing_writes: got %0d left want 0", name, exp_wr.size());
        end
        total++;
        if (lb_we !== 1'b0 || dram_req !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_outputs: got we=%b req=%b want 0 0", name, lb_we, dram_req);
        end
        if (rate_full && nw > 2) begin
            total++;
            if (!saw_gap) begin
                bad++;
                $display("FAIL %s fifo_backpressure: got gap=%b want 1", name, saw_gap);
            end
        end
    endtask

    task automatic random_task(input string name, input bit busy_go, input bit rate_full);
        random_data();
        run_task(6'($urandom), 9'($urandom), 8'($urandom), 9'($urandom), 3'($urandom),
                 1'($urandom), 4'($urandom), -1, busy_go, rate_full, name);
    endtask

    task automatic test_reset();
        total++;
        if (tsr_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", tsr_rdy); end
        total++;
        if (dram_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", dram_req); end
        total++;
        if (lb_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", lb_we); end
        total++;
        if (lb_waddr !== 9'd0) begin bad++; $display("FAIL reset_waddr: got %0d want 0", lb_waddr); end
        total++;
        if (lb_wdata !== 8'd0) begin bad++; $display("FAIL reset_wdata: got %h want 0", lb_wdata); end
    endtask

    task automatic test_basic();
        data[0] = 16'h1234;
        data[1] = 16'h5670;
        run_task(6'd3, 9'h00A, 8'h10, 9'd16, 3'd0, 1'b0, 4'd5, -1, 0, 0, "t1_plain");
        run_task(6'd3, 9'h00A, 8'h10, 9'd16, 3'd0, 1'b1, 4'd5, -1, 0, 0, "t2_xflip");
    endtask

    task automatic test_wide();
        random_data();
        run_task(6'd63, 9'h1C0, 8'hFE, 9'($urandom), 3'd7, 1'($urandom), 4'($urandom), -1, 0, 1, "t3_wide");
    endtask

    task automatic test_edges();
        for (int k = 0; k < 16; k++) data[k] = 16'hFFFF;
        run_task(6'($urandom), 9'($urandom), 8'($urandom), 9'd356, 3'd0, 1'b0, 4'd9, -1, 0, 0, "t4_right_edge");
        run_task(6'($urandom), 9'($urandom), 8'($urandom), 9'd508, 3'd0, 1'b0, 4'd2, -1, 0, 0, "t5_wrap");
        run_task(6'($urandom), 9'($urandom), 8'($urandom), 9'd508, 3'd1, 1'b1, 4'd7, -1, 0, 1, "t5_wrap_flip");
    endtask

    task automatic test_stall();
        random_data();
        run_task(6'($urandom), 9'($urandom), 8'($urandom), 9'($urandom), 3'd3, 1'($urandom),
                 4'($urandom), 3, 0, 0, "t6_stall");
    endtask

    // Abort a task with start or rst while its third word is being requested
    task automatic test_abort(input bit use_rst);
        bit hit;
        int kf;
        hit = 0;
        kf  = 0;
        random_data();
        scramble_fields();
        tsr_xs = 3'd3;
        tsr_go = 1'b1;
        tick();
        tsr_go = 1'b0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            if (kf == 2 && dram_req === 1'b1) begin
                hit       = 1;
                dram_next = 1'b0;
                if (use_rst) rst = 1'b1;
                else         start = 1'b1;
            end else begin
                dram_next  = 1'($urandom_range(0, 1));
                dram_rdata = data[kf % 16];
                if (dram_req === 1'b1 && dram_next === 1'b1) kf++;
            end
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        total++;
        if (!hit) begin bad++; $display("FAIL t7_abort_trigger: got kf=%0d want abort point reached", kf); end
        total++;
        if (tsr_rdy !== 1'b1) begin bad++; $display("FAIL t7_abort_rdy: got %b want 1", tsr_rdy); end
        for (int cyc = 0; cyc < 20; cyc++) begin
            dram_next  = 1'($urandom_range(0, 1));
            dram_rdata = 16'($urandom);
            total++;
            if (lb_we !== 1'b0 || dram_req !== 1'b0 || tsr_rdy !== 1'b1) begin
                bad++;
                $display("FAIL t7_after_abort: got we=%b req=%b rdy=%b want 0 0 1", lb_we, dram_req, tsr_rdy);
            end
            tick();
        end
        dram_next = 1'b0;
        start  = 1'b1;
        tsr_go = 1'b1;
        tick();
        start  = 1'b0;
        tsr_go = 1'b0;
        total++;
        if (tsr_rdy !== 1'b1 || dram_req !== 1'b0) begin
            bad++;
            $display("FAIL t7_start_priority: got rdy=%b req=%b want 1 0", tsr_rdy, dram_req);
        end
        random_task(use_rst ? "t7_after_rst" : "t7_after_start", 0, 0);
    endtask

    task automatic test_busy_go();
        random_task("t8_busy_go", 1, 0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            dram_next = 1'b1;
            total++;
            if (dram_req !== 1'b0 || tsr_rdy !== 1'b1) begin
                bad++;
                $display("FAIL t8_no_second_task: got req=%b rdy=%b want 0 1", dram_req, tsr_rdy);
            end
            tick();
        end
        dram_next = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            random_task("random", i % 5 == 2, i % 2 == 0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        tsr_go     = 1'b0;
        dram_next  = 1'b0;
        dram_rdata = 16'd0;
        scramble_fields();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_wide();
        test_edges();
        test_stall();
        test_abort(0);
        test_abort(1);
        test_busy_go();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
